// File: rtl/fsk_tone_generator.sv
// -----------------------------------------------------------------------------
// fsk_tone_generator
//
// Binary-FSK square-wave transmitter. Each data bit accepted over a
// valid/ready handshake is sent as one symbol lasting SYMBOL_TICKS enabled
// clock cycles. Bit 0 is sent as a FREQUENCY0 tone and bit 1 as a FREQUENCY1
// tone. Symbols that follow each other without a gap are phase-continuous.
//
// Handshake: a bit is transferred on a rising clock edge where data_valid and
// data_ready are both 1. data_ready is a function of enable, clear and the
// internal state only; it never looks at data_valid. A producer may hold
// data_valid high for as long as it likes, and the bit is taken on the first
// edge where data_ready is also high.
//
// Ports:
//   clock        in   system clock, rising edge
//   clear        in   asynchronous active-high reset
//   enable       in   run/pause; 0 freezes every register
//   data_valid   in   a data bit is offered
//   data_bit     in   the bit offered
//   data_ready   out  a bit is accepted this cycle if data_valid is 1
//   sample_data  out  FSK square wave (0 while idle)
//   busy         out  a symbol is being transmitted (state == TONE)
//   symbols_sent out  count of completed symbols, wraps at 2^32
// -----------------------------------------------------------------------------
module fsk_tone_generator #(
    parameter int FREQUENCY0      = 9000,
    parameter int FREQUENCY1      = 11000,
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int SYMBOL_TICKS    = 50000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        enable,
    input  logic        data_valid,
    input  logic        data_bit,
    output logic        data_ready,
    output logic        sample_data,
    output logic        busy,
    output logic [31:0] symbols_sent
);

    // Half-period lengths in clock cycles for each tone.
    localparam int HALF0    = CLOCK_FREQUENCY / (2 * FREQUENCY0);
    localparam int HALF1    = CLOCK_FREQUENCY / (2 * FREQUENCY1);
    localparam int HALF_MAX = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int SYM_W    = (SYMBOL_TICKS > 1) ? $clog2(SYMBOL_TICKS) : 1;

    localparam logic [SYM_W-1:0]  SYM_LAST   = SYM_W'(SYMBOL_TICKS - 1);
    localparam logic [HALF_W-1:0] HALF0_LAST = HALF_W'(HALF0 - 1);
    localparam logic [HALF_W-1:0] HALF1_LAST = HALF_W'(HALF1 - 1);

    typedef enum logic {
        IDLE = 1'b0,
        TONE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic                cur_bit_q, cur_bit_d;
    logic                level_q, level_d;
    logic [31:0]         sent_q, sent_d;

    logic                sym_last;
    logic                half_last;
    logic                ready;
    logic                accept;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= IDLE;
            sym_cnt_q  <= '0;
            half_cnt_q <= '0;
            cur_bit_q  <= 1'b0;
            level_q    <= 1'b0;
            sent_q     <= '0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            half_cnt_q <= half_cnt_d;
            cur_bit_q  <= cur_bit_d;
            level_q    <= level_d;
            sent_q     <= sent_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        half_cnt_d = half_cnt_q;
        cur_bit_d  = cur_bit_q;
        level_d    = level_q;
        sent_d     = sent_q;

        sym_last  = (state_q == TONE) && (sym_cnt_q == SYM_LAST);
        half_last = (half_cnt_q == (cur_bit_q ? HALF1_LAST : HALF0_LAST));

        // clear is folded in so data_ready reads 0 for the whole time clear
        // is asserted, not only after the next edge.
        ready  = enable && !clear && ((state_q == IDLE) || sym_last);
        accept = ready && data_valid;

        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d    = TONE;
                        cur_bit_d  = data_bit;
                        sym_cnt_d  = '0;
                        half_cnt_d = '0;
                        level_d    = 1'b1;
                    end
                end

                TONE: begin
                    if (sym_last) begin
                        sent_d     = sent_q + 32'd1;
                        sym_cnt_d  = '0;
                        half_cnt_d = '0;
                        if (accept) begin
                            // Chaining: apply the half-period toggle that is
                            // due on this last cycle (if any) so the wave
                            // continues without a phase jump.
                            cur_bit_d = data_bit;
                            level_d   = half_last ? ~level_q : level_q;
                        end else begin
                            state_d = IDLE;
                            level_d = 1'b0;
                        end
                    end else begin
                        sym_cnt_d = sym_cnt_q + SYM_W'(1);
                        if (half_last) begin
                            half_cnt_d = '0;
                            level_d    = ~level_q;
                        end else begin
                            half_cnt_d = half_cnt_q + HALF_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign data_ready   = ready;
    assign sample_data  = level_q;
    assign busy         = (state_q == TONE);
    assign symbols_sent = sent_q;

endmodule

// File: tb/tb_fsk_tone_generator.sv
// -----------------------------------------------------------------------------
// tb_fsk_tone_generator
//
// Bench for fsk_tone_generator at CLOCK_FREQUENCY=1000, FREQUENCY0=50,
// FREQUENCY1=100, SYMBOL_TICKS=40 (HALF0=10, HALF1=5).
//
// Streams are described as a list of bits; the reference model turns the list
// into an expected per-cycle waveform (inputs to drive plus expected outputs)
// using the symbol timing rules: within a symbol, the level at enabled
// position p is start_level ^ ((p / HALF) odd), every symbol of a
// back-to-back stream begins where the previous one's wave left off, and
// paused cycles simply repeat the current outputs.
// -----------------------------------------------------------------------------
module tb_fsk_tone_generator;

    localparam int CLK_F = 1000;
    localparam int F0    = 50;
    localparam int F1    = 100;
    localparam int ST    = 40;
    localparam int H0    = CLK_F / (2 * F0);
    localparam int H1    = CLK_F / (2 * F1);

    logic        clock;
    logic        clear;
    logic        enable;
    logic        data_valid;
    logic        data_bit;
    logic        data_ready;
    logic        sample_data;
    logic        busy;
    logic [31:0] symbols_sent;

    int checks;
    int errors;

    logic [31:0] exp_sent;

    // One entry per clock cycle: inputs to drive and outputs expected.
    typedef struct {
        logic        en;
        logic        vld;
        logic        din;
        logic        smp;
        logic        bsy;
        logic        rdy;
        logic [31:0] cnt;
    } rec_t;

    rec_t rec_q[$];
    logic bits_q[$];

    fsk_tone_generator #(
        .FREQUENCY0      (F0),
        .FREQUENCY1      (F1),
        .CLOCK_FREQUENCY (CLK_F),
        .SYMBOL_TICKS    (ST)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .enable       (enable),
        .data_valid   (data_valid),
        .data_bit     (data_bit),
        .data_ready   (data_ready),
        .sample_data  (sample_data),
        .busy         (busy),
        .symbols_sent (symbols_sent)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // -------------------------------------------------------------------------
    // Reference model: build the expected waveform for the stream in bits_q.
    // One accept cycle from idle, then every symbol, then one idle cycle.
    // freeze_sym/freeze_p/freeze_n insert a deterministic pause;
    // rand_pct adds random short pauses.
    // -------------------------------------------------------------------------
    task automatic build_stream(input int freeze_sym, input int freeze_p,
                                input int freeze_n, input int rand_pct);
        rec_t r;
        logic l0;
        logic lvl;
        int   h;
        int   n;
        int   nf;
        bit   last;
        bit   nxt;
        rec_q.delete();
        n = bits_q.size();

        r.en = 1'b1; r.vld = 1'b1; r.din = bits_q[0];
        r.smp = 1'b0; r.bsy = 1'b0; r.rdy = 1'b1; r.cnt = exp_sent;
        rec_q.push_back(r);

        l0 = 1'b1;
        for (int s = 0; s < n; s++) begin
            h = bits_q[s] ? H1 : H0;
            for (int p = 0; p < ST; p++) begin
                lvl = l0 ^ (((p / h) % 2) == 1);
                nf = (s == freeze_sym && p == freeze_p) ? freeze_n : 0;
                if (rand_pct > 0 && $urandom_range(99) < rand_pct)
                    nf += $urandom_range(3, 1);
                for (int f = 0; f < nf; f++) begin
                    r.en = 1'b0; r.vld = 1'($urandom_range(1)); r.din = 1'($urandom_range(1));
                    r.smp = lvl; r.bsy = 1'b1; r.rdy = 1'b0; r.cnt = exp_sent;
                    rec_q.push_back(r);
                end
                last = (p == ST - 1);
                nxt  = last && (s + 1 < n);
                r.en  = 1'b1;
                r.vld = nxt ? 1'b1 : (last ? 1'b0 : 1'($urandom_range(1)));
                r.din = nxt ? bits_q[s+1] : 1'($urandom_range(1));
                r.smp = lvl; r.bsy = 1'b1; r.rdy = last; r.cnt = exp_sent;
                rec_q.push_back(r);
            end
            exp_sent = exp_sent + 32'd1;
            // Starting level of the next symbol: the wave simply continues,
            // including a half-period boundary that lands on the symbol edge.
            if (ST % h == 0)
                l0 = l0 ^ (((ST / h) % 2) == 1);
            else
                l0 = l0 ^ ((((ST - 1) / h) % 2) == 1);
        end

        r.en = 1'b1; r.vld = 1'b0; r.din = 1'b0;
        r.smp = 1'b0; r.bsy = 1'b0; r.rdy = 1'b1; r.cnt = exp_sent;
        rec_q.push_back(r);
    endtask

    // Drive the expected-waveform table; called at posedge+1.
    task automatic run_stream(input string name);
        rec_t r;
        for (int i = 0; i < rec_q.size(); i++) begin
            r = rec_q[i];
            enable     = r.en;
            data_valid = r.vld;
            data_bit   = r.din;
            #1;
            checks++;
            if (sample_data !== r.smp) begin
                errors++;
                $display("FAIL %s sample_data cycle %0d: got %0b expected %0b", name, i, sample_data, r.smp);
            end
            checks++;
            if (busy !== r.bsy) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %0b expected %0b", name, i, busy, r.bsy);
            end
            checks++;
            if (data_ready !== r.rdy) begin
                errors++;
                $display("FAIL %s data_ready cycle %0d: got %0b expected %0b", name, i, data_ready, r.rdy);
            end
            checks++;
            if (symbols_sent !== r.cnt) begin
                errors++;
                $display("FAIL %s symbols_sent cycle %0d: got %0d expected %0d", name, i, symbols_sent, r.cnt);
            end
            @(posedge clock);
            #1;
        end
        data_valid = 1'b0;
        enable     = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        clear      = 1'b1;
        enable     = 1'b1;
        data_valid = 1'b1;
        data_bit   = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (sample_data !== 1'b0) begin errors++; $display("FAIL reset sample_data: got %0b expected 0", sample_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %0b expected 0", busy); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL reset data_ready: got %0b expected 0", data_ready); end
        checks++;
        if (symbols_sent !== 32'd0) begin errors++; $display("FAIL reset symbols_sent: got %0d expected 0", symbols_sent); end
        data_valid = 1'b0;
        clear      = 1'b0;
        exp_sent   = 32'd0;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL idle data_ready: got %0b expected 1", data_ready); end
        // Paused while idle: not ready, and an offered bit is ignored.
        enable     = 1'b0;
        data_valid = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL paused data_ready: got %0b expected 0", data_ready); end
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL paused accept busy: got %0b expected 0", busy); end
        data_valid = 1'b0;
        enable     = 1'b1;
    endtask

    task automatic test_single_bit0();
        bits_q = '{1'b0};
        build_stream(-1, 0, 0, 0);
        run_stream("single_bit0");
    endtask

    task automatic test_back_to_back_11();
        bits_q = '{1'b1, 1'b1};
        build_stream(-1, 0, 0, 0);
        run_stream("b2b_11");
    endtask

    task automatic test_back_to_back_01();
        bits_q = '{1'b0, 1'b1};
        build_stream(-1, 0, 0, 0);
        run_stream("b2b_01");
    endtask

    task automatic test_enable_pause();
        bits_q = '{1'b0};
        build_stream(0, 15, 7, 0);
        run_stream("enable_pause");
    endtask

    task automatic test_clear_mid_symbol();
        enable     = 1'b1;
        data_valid = 1'b1;
        data_bit   = 1'b0;
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        repeat (22) @(posedge clock);
        #1;
        // Cycle 23 of a bit-0 symbol lies in the second high half-period.
        checks++;
        if (sample_data !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre sample/busy: got %0b/%0b expected 1/1", sample_data, busy);
        end
        #2;
        clear = 1'b1;
        #1;
        exp_sent = 32'd0;
        checks++;
        if (sample_data !== 1'b0) begin errors++; $display("FAIL clear sample_data: got %0b expected 0", sample_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clear busy: got %0b expected 0", busy); end
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL clear data_ready: got %0b expected 0", data_ready); end
        checks++;
        if (symbols_sent !== exp_sent) begin errors++; $display("FAIL clear symbols_sent: got %0d expected %0d", symbols_sent, exp_sent); end
        @(posedge clock);
        #1;
        clear      = 1'b0;
        data_valid = 1'b1;
        data_bit   = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL restart data_ready: got %0b expected 1", data_ready); end
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        checks++;
        if (sample_data !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart sample/busy: got %0b/%0b expected 1/1", sample_data, busy);
        end
        repeat (ST) @(posedge clock);
        #1;
        exp_sent = exp_sent + 32'd1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL restart end busy: got %0b expected 0", busy); end
        checks++;
        if (symbols_sent !== exp_sent) begin errors++; $display("FAIL restart symbols_sent: got %0d expected %0d", symbols_sent, exp_sent); end
    endtask

    task automatic test_random_streams();
        int n;
        for (int it = 0; it < 6; it++) begin
            bits_q.delete();
            n = $urandom_range(4, 1);
            for (int k = 0; k < n; k++)
                bits_q.push_back(1'($urandom_range(1)));
            build_stream(-1, 0, 0, 4);
            run_stream("random_stream");
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        checks     = 0;
        errors     = 0;
        exp_sent   = 32'd0;
        clear      = 1'b1;
        enable     = 1'b0;
        data_valid = 1'b0;
        data_bit   = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_single_bit0();
        test_back_to_back_11();
        test_back_to_back_01();
        test_enable_pause();
        test_clear_mid_symbol();
        test_random_streams();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
